// File: rtl/ones_serial.sv
// ones_serial: bit-serial pass / ones' complement / two's complement / absolute
// value unit. A word is accepted in IDLE, walked LSB first through a one-bit
// carry chain in RUN, and presented in parallel in DONE until the consumer
// takes it. The per-bit result is also exposed as a serial stream.
module ones_serial #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] i,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             ovf,
  output logic             so_bit,
  output logic             so_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0]       MODE_PASS = 2'b00;
  localparam logic [1:0]       MODE_ONES = 2'b01;
  localparam logic [1:0]       MODE_TWOS = 2'b10;
  localparam logic [1:0]       MODE_ABS  = 2'b11;
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;

  // Operand being consumed, result being assembled, and the held output word.
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] o_q;

  logic [1:0]       mode_q;
  logic             neg;
  logic             carry;
  logic             carry_nxt;
  logic             min_q;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             neg_in;
  logic             last_bit;
  logic             r;

  // Result bit for one serial step. When negating, ~b plus the running carry
  // gives the two's complement; otherwise the bit is passed or inverted.
  function automatic logic serial_bit(input logic b, input logic [1:0] m,
                                      input logic n, input logic c);
    logic res_b;
    if (n) begin
      res_b = ~b ^ c;
    end else if (m == MODE_ONES) begin
      res_b = ~b;
    end else begin
      res_b = b;
    end
    return res_b;
  endfunction

  // Carry out of one negation step; only meaningful while negating.
  function automatic logic serial_carry(input logic b, input logic n,
                                        input logic c);
    return n & ~b & c;
  endfunction

  // Handshake qualifiers and the per-cycle serial datapath.
  always_comb begin
    accept    = in_valid && in_ready;
    neg_in    = (mode == MODE_TWOS) || ((mode == MODE_ABS) && i[WIDTH-1]);
    last_bit  = (cnt == LAST_CNT);
    r         = serial_bit(shreg[0], mode_q, neg, carry);
    carry_nxt = serial_carry(shreg[0], neg, carry);
    res_nxt   = {r, res[WIDTH-1:1]};
  end

  // Next-state logic and Moore outputs of the IDLE/RUN/DONE controller.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    so_valid  = 1'b0;
    so_bit    = 1'b0;
    ovf       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !reset;
        if (accept) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        so_valid = 1'b1;
        so_bit   = r;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        ovf       = neg && min_q;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture, serial shift/carry chain and output word hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      res    <= '0;
      o_q    <= '0;
      mode_q <= MODE_PASS;
      neg    <= 1'b0;
      carry  <= 1'b0;
      min_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg  <= i;
            res    <= '0;
            mode_q <= mode;
            neg    <= neg_in;
            carry  <= neg_in;
            min_q  <= (i == MIN_VAL);
            cnt    <= '0;
          end
        end
        RUN: begin
          shreg <= shreg >> 1;
          res   <= res_nxt;
          carry <= carry_nxt;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            o_q <= res_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o = o_q;

endmodule

// File: tb/tb_ones_serial.sv
// Bench for ones_serial: a 4-bit instance for the directed scenarios and an
// 8-bit instance for the exhaustive sweep, both checked against an arithmetic
// reference and a per-cycle output monitor.
module tb_ones_serial;

  typedef struct {
    logic [7:0] o;
    logic       f;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       v4 = 1'b0, rdy4, ov4, or4 = 1'b1, f4, sb4, sv4;
  logic [3:0] i4 = '0, o4;
  logic [1:0] m4 = '0;

  logic       v8 = 1'b0, rdy8, ov8, or8 = 1'b1, f8, sb8, sv8;
  logic [7:0] i8 = '0, o8;
  logic [1:0] m8 = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ovf8 = 0;

  exp_t q4[$];
  exp_t q8[$];
  logic [7:0] s4 = '0, s8 = '0;
  int n4 = 0, n8 = 0;

  always #5 clk = ~clk;

  ones_serial #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(v4), .in_ready(rdy4), .i(i4),
    .mode(m4), .out_valid(ov4), .out_ready(or4), .o(o4), .ovf(f4),
    .so_bit(sb4), .so_valid(sv4)
  );

  ones_serial #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8), .i(i8),
    .mode(m8), .out_valid(ov8), .out_ready(or8), .o(o8), .ovf(f8),
    .so_bit(sb8), .so_valid(sv8)
  );

  // Reference: the four operations as plain modulo-2^w arithmetic.
  function automatic int ref_o(input int w, input int x, input int m);
    int mask;
    mask = (1 << w) - 1;
    case (m)
      0: return x & mask;
      1: return ~x & mask;
      2: return (-x) & mask;
      default: return (((x >> (w - 1)) & 1) == 1) ? ((-x) & mask) : (x & mask);
    endcase
  endfunction

  function automatic int ref_f(input int w, input int x, input int m);
    return ((m == 2 || m == 3) && (x == (1 << (w - 1)))) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Output monitor: stability of o/ovf throughout DONE, serial stream versus
  // the parallel result, and one queued expectation per transfer.
  always @(negedge clk) begin
    if (reset) begin
      n4 = 0; n8 = 0; s4 = '0; s8 = '0;
    end else begin
      if (sv4) begin
        if (n4 < 8) s4[n4] = sb4;
        n4++;
      end
      if (ov4) begin
        if (q4.size() == 0) chk("w4_unexpected_out_valid", 1, 0);
        else begin
          chk("w4_o", {28'd0, o4}, {24'd0, q4[0].o});
          chk("w4_ovf", f4, q4[0].f);
          if (or4) begin
            chk("w4_so_len", n4, 4);
            chk("w4_so_stream", {28'd0, s4[3:0]}, {24'd0, q4[0].o});
            void'(q4.pop_front());
            n4 = 0; s4 = '0;
          end
        end
      end
      if (sv8) begin
        if (n8 < 8) s8[n8] = sb8;
        n8++;
      end
      if (ov8) begin
        if (q8.size() == 0) chk("w8_unexpected_out_valid", 1, 0);
        else begin
          chk("w8_o", {24'd0, o8}, {24'd0, q8[0].o});
          chk("w8_ovf", f8, q8[0].f);
          if (or8) begin
            chk("w8_so_len", n8, 8);
            chk("w8_so_stream", {24'd0, s8}, {24'd0, q8[0].o});
            if (f8) n_ovf8++;
            void'(q8.pop_front());
            n8 = 0; s8 = '0;
          end
        end
      end
    end
  end

  task automatic send4(input int x, input int m);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!rdy4 && t < 100) begin @(negedge clk); t++; end
    chk("w4_in_ready_timeout", rdy4, 1);
    i4 = x[3:0]; m4 = m[1:0]; v4 = 1'b1;
    e.o = 8'(ref_o(4, x, m)); e.f = ref_f(4, x, m) != 0;
    q4.push_back(e);
    @(posedge clk); #1;
    v4 = 1'b0; i4 = 4'($urandom); m4 = 2'($urandom);
  endtask

  task automatic send8(input int x, input int m);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!rdy8 && t < 100) begin @(negedge clk); t++; end
    if (!rdy8) chk("w8_in_ready_timeout", rdy8, 1);
    i8 = x[7:0]; m8 = m[1:0]; v8 = 1'b1;
    e.o = 8'(ref_o(8, x, m)); e.f = ref_f(8, x, m) != 0;
    q8.push_back(e);
    @(posedge clk); #1;
    v8 = 1'b0; i8 = 8'($urandom); m8 = 2'($urandom);
  endtask

  // Wait (bounded) for the 4-bit result and pin it to a hand-computed value.
  task automatic result4(input string nm, input int exp_o, input int exp_f);
    int t;
    t = 0;
    @(negedge clk);
    while (!ov4 && t < 50) begin @(negedge clk); t++; end
    chk({nm, "_out_valid"}, ov4, 1);
    chk({nm, "_o"}, {28'd0, o4}, exp_o);
    chk({nm, "_ovf"}, f4, exp_f);
  endtask

  logic [3:0] so_exp;
  logic [3:0] o_hold;

  initial begin
    // Hand-computed pins on the reference itself.
    chk("ref_ones_0101", ref_o(4, 5, 1), 4'b1010);
    chk("ref_twos_0101", ref_o(4, 5, 2), 4'b1011);
    chk("ref_abs_1011", ref_o(4, 11, 3), 4'b0101);
    chk("ref_abs_80", ref_o(8, 'h80, 3), 'h80);
    chk("ref_ovf_80", ref_f(8, 'h80, 2), 1);
    chk("ref_ovf_7f", ref_f(8, 'h7f, 3), 0);

    // Reset state.
    #1;
    chk("rst_in_ready", rdy4, 0);
    chk("rst_out_valid", ov4, 0);
    chk("rst_o", {28'd0, o4}, 0);
    chk("rst_so_valid", sv4, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1 chk("rst_release_in_ready", rdy4, 1);

    // Ones' complement with serial-stream timing.
    or4 = 1'b1;
    so_exp = 4'b1010;
    send4(4'b0101, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_so_valid", sv4, 1);
      chk("t2_so_bit", sb4, so_exp[k]);
    end
    @(negedge clk);
    chk("t2_out_valid", ov4, 1);
    chk("t2_o", {28'd0, o4}, 4'b1010);
    chk("t2_ovf", f4, 0);
    @(negedge clk);
    chk("t2_in_ready_after", rdy4, 1);

    // Asynchronous reset in the middle of RUN.
    send4(4'b0101, 2);
    @(negedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("t1_in_ready", rdy4, 0);
    chk("t1_out_valid", ov4, 0);
    chk("t1_o", {28'd0, o4}, 0);
    chk("t1_ovf", f4, 0);
    chk("t1_so_bit", sb4, 0);
    chk("t1_so_valid", sv4, 0);
    q4.delete();
    @(negedge clk);
    @(posedge clk); #3;
    reset = 1'b0;
    #1 chk("t1_in_ready_release", rdy4, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t1_no_out_valid", ov4, 0);
    end

    // Two's complement and absolute value, including the boundaries.
    send4(4'b0101, 2); result4("t3_twos_0101", 4'b1011, 0);
    send4(4'b0000, 2); result4("t3_twos_0000", 4'b0000, 0);
    send4(4'b1011, 3); result4("t4_abs_1011", 4'b0101, 0);
    send4(4'b0011, 3); result4("t4_abs_0011", 4'b0011, 0);
    send4(4'b1000, 3); result4("t4_abs_1000", 4'b1000, 1);

    // Backpressure in DONE, with ignored input offers.
    @(negedge clk);
    or4 = 1'b0;
    send4(4'b1000, 2);
    result4("t5_first", 4'b1000, 1);
    o_hold = o4;
    for (int k = 0; k < 7; k++) begin
      if (k % 2 == 0) begin
        v4 = 1'b1; i4 = 4'($urandom); m4 = 2'($urandom);
      end else begin
        v4 = 1'b0;
      end
      @(negedge clk);
      chk("t5_out_valid_held", ov4, 1);
      chk("t5_o_held", {28'd0, o4}, {28'd0, o_hold});
      chk("t5_ovf_held", f4, 1);
      chk("t5_in_ready_low", rdy4, 0);
    end
    v4 = 1'b0;
    or4 = 1'b1;
    @(negedge clk);
    chk("t5_released_out_valid", ov4, 0);
    chk("t5_released_idle", rdy4, 1);
    chk("t5_single_transfer", q4.size(), 0);
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_extra_word", ov4, 0);
    end

    // Exhaustive sweep on the 8-bit instance.
    or8 = 1'b1;
    for (int x = 0; x < 256; x++) begin
      for (int m = 0; m < 4; m++) begin
        send8(x, m);
      end
    end
    begin
      int t;
      t = 0;
      while ((q8.size() != 0 || q4.size() != 0) && t < 100) begin
        @(negedge clk); t++;
      end
    end
    chk("drain_q4", q4.size(), 0);
    chk("drain_q8", q8.size(), 0);
    chk("w8_ovf_count", n_ovf8, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ones_serial.md
Name: ones_serial

Overview:
Parametrised, sequential successor to the combinational ones block. It accepts a WIDTH-bit word through a valid/ready handshake and processes it one bit per cycle, LSB first, through a serial carry chain. Four modes are supported: pass, ones' complement, two's complement and absolute value. The result is presented in parallel behind an output handshake, and the serial bit stream is also exposed for bit-serial multiplier datapaths.

Parameters:
WIDTH, 4, data word width in bits; legal values >= 2.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, do not override.

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  input word offered.
in_ready  output  1  block can accept a word this cycle.
i  input  WIDTH  operand, captured when in_valid & in_ready.
mode  input  2  00 pass, 01 ones' complement, 10 two's complement, 11 absolute value; captured with i.
out_valid  output  1  o and ovf are valid.
out_ready  input  1  consumer accepts the result.
o  output  WIDTH  result word.
ovf  output  1  two's complement or abs overflow (operand was the most-negative value).
so_bit  output  1  serial result bit, LSB first.
so_valid  output  1  so_bit is valid this cycle.

Behaviour:
- Reset (async, active-high) forces the following immediately, independent of clk:
  - state = IDLE;
  - in_ready = 0 while reset is high, 1 in the first cycle after release;
  - out_valid = 0, o = 0, ovf = 0, so_bit = 0, so_valid = 0;
  - internal shift register, carry and counter = 0.
- Reset mid-operation abandons the word; no partial result is ever presented.
- States:
  - IDLE: in_ready = 1. On in_valid, capture i into the shift register and mode into a mode register. Set the effective negate flag: neg = 1 for mode 10, or for mode 11 when i[WIDTH-1] = 1. Set carry = neg. Clear the counter. Go to RUN.
  - RUN: in_ready = 0. Each cycle handles bit b = shreg[0]:
    - mode 00, or mode 11 with neg = 0: r = b.
    - mode 01: r = ~b.
    - neg = 1: r = ~b ^ carry; next carry = ~b & carry.
    - r shifts into the MSB of the result register (LSB-first assembly).
    - so_bit = r, so_valid = 1.
    - counter increments.
    - When counter reaches WIDTH-1 in this cycle, go to DONE next.
  - DONE: out_valid = 1 and so_valid = 0. o holds the full result and stays stable until out_ready. On out_valid & out_ready, go to IDLE.
- Latency: input accept at edge N → so_valid in cycles N+1..N+WIDTH → out_valid asserted from cycle N+WIDTH+1.
- No input/output overlap: in_ready is low in RUN and DONE. Throughput is one word per WIDTH+2 cycles when out_ready is held high.
- ovf: set in DONE iff neg = 1 and the captured operand was 1 followed by WIDTH-1 zeros (result equals operand). Otherwise 0. Cleared on leaving DONE.
- Boundaries:
  - Operand 0 in mode 10 → o = 0, ovf = 0; the final carry-out is discarded.
  - mode 11 with a positive operand behaves exactly as pass.
  - in_valid in RUN or DONE is ignored; i and mode may change freely there.
  - out_ready while not in DONE is ignored.
- All arithmetic is WIDTH bits, modulo 2^WIDTH.

Test Plan:
1. Reset asserted asynchronously mid-RUN (WIDTH=4, i=0101, mode 10) → all outputs 0 with no clock edge; in_ready=1 after release; no out_valid follows.
2. i=0101, mode 01, out_ready=1 → so_bit sequence 0,1,0,1 over 4 cycles; out_valid in cycle 5 with o=1010, ovf=0; in_ready=1 the cycle after.
3. i=0101, mode 10 → o=1011, ovf=0. Then i=0000, mode 10 → o=0000, ovf=0.
4. i=1011, mode 11 → o=0101. Then i=0011, mode 11 → o=0011. Then i=1000, mode 11 → o=1000, ovf=1.
5. Backpressure: out_ready=0 for 7 cycles in DONE → o, ovf, out_valid stable; in_ready=0; in_valid pulses ignored. Release → single transfer, then IDLE.
6. Sweep WIDTH=8, all 256 operands × 4 modes against a reference model (pass, ~i, -i, |i|) → full match, including ovf only for 0x80 in modes 10/11.
